// File: rtl/cam_timing_gen.sv
// cam_timing_gen: OV7670-style camera source producing vsync/href/data on pclk
// for cam_read. Frames are QVGA RGB565, two bytes per pixel, high byte first.
// Optional feature: define CAM_TPG_LFSR_EN to turn pattern 3 into a 16-bit
// Fibonacci LFSR stream; without it pattern 3 repeats the counter pattern.
module cam_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 119,
  parameter int LINES    = 240,
  parameter int V_SYNC   = 4704,
  parameter int V_BACK   = 26656,
  parameter int V_FRONT  = 0
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  // One shared timer covers every blanking phase, so size it for the longest.
  localparam int T_MAX_A = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
  localparam int T_MAX_B = (H_BLANK > V_FRONT) ? H_BLANK : V_FRONT;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int TW      = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int BW      = $clog2(H_ACTIVE);
  localparam int LW      = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int PW      = $clog2(BAR_W);

  localparam logic [TW-1:0] VS_LAST   = TW'(V_SYNC - 1);
  localparam logic [TW-1:0] VB_LAST   = TW'(V_BACK - 1);
  localparam logic [TW-1:0] HB_LAST   = TW'(H_BLANK - 1);
  localparam logic [TW-1:0] VF_LAST   = TW'((V_FRONT > 0) ? (V_FRONT - 1) : 0);
  localparam logic [BW-1:0] BYTE_LAST = BW'(H_ACTIVE - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(LINES - 1);
  localparam logic [PW-1:0] BAR_LAST  = PW'(BAR_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_HBLANK,
    ST_VFRONT
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [TW-1:0]   tmr;
  logic [BW-1:0]   byte_cnt;
  logic [LW-1:0]   line_cnt;
  logic [PW-1:0]   bar_pos;
  logic [2:0]      bar_idx;
  logic [1:0]      patt;
  logic            vsync_entry;
  logic            last_line_end;
  logic [15:0]     bar_rgb;
  logic [7:0]      cnt_byte;
  logic [7:0]      pix;

`ifdef CAM_TPG_LFSR_EN
  logic [15:0]     lfsr;
  logic            lfsr_fb;
`endif

  // RGB565 value of each of the eight vertical colour bars, left to right.
  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = 16'hFFFF;
      3'd1:    bar_colour = 16'hFFE0;
      3'd2:    bar_colour = 16'h07FF;
      3'd3:    bar_colour = 16'h07E0;
      3'd4:    bar_colour = 16'hF81F;
      3'd5:    bar_colour = 16'hF800;
      3'd6:    bar_colour = 16'h001F;
      default: bar_colour = 16'h0000;
    endcase
  endfunction

  // State register; frames always run to completion once started.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next-state logic plus the frame-level strobes derived from it.
  always_comb begin
    state_next    = state;
    vsync_entry   = 1'b0;
    last_line_end = 1'b0;
    case (state)
      ST_IDLE:   if (enable) state_next = ST_VSYNC;
      ST_VSYNC:  if (tmr == VS_LAST) state_next = ST_VBACK;
      ST_VBACK:  if (tmr == VB_LAST) state_next = ST_ACTIVE;
      ST_ACTIVE: if (byte_cnt == BYTE_LAST) state_next = ST_HBLANK;
      ST_HBLANK: begin
        if (tmr == HB_LAST) begin
          if (line_cnt != LINE_LAST)  state_next = ST_ACTIVE;
          else if (V_FRONT != 0)      state_next = ST_VFRONT;
          else if (enable)            state_next = ST_VSYNC;
          else                        state_next = ST_IDLE;
        end
      end
      ST_VFRONT: begin
        if (tmr == VF_LAST) state_next = enable ? ST_VSYNC : ST_IDLE;
      end
      default:   state_next = ST_IDLE;
    endcase
    vsync_entry   = (state_next == ST_VSYNC) && (state != ST_VSYNC);
    last_line_end = (state == ST_HBLANK) && (tmr == '0) && (line_cnt == LINE_LAST);
  end

  // Phase timer restarts on every state change and idles in IDLE/ACTIVE.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      tmr <= '0;
    end else if ((state_next != state) || (state == ST_IDLE) || (state == ST_ACTIVE)) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + TW'(1);
    end
  end

  // Byte position and colour-bar position within the active line.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      byte_cnt <= '0;
      bar_pos  <= '0;
      bar_idx  <= 3'd0;
    end else if ((state == ST_ACTIVE) && (byte_cnt != BYTE_LAST)) begin
      byte_cnt <= byte_cnt + BW'(1);
      if (bar_pos == BAR_LAST) begin
        bar_pos <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_pos <= bar_pos + PW'(1);
      end
    end else begin
      byte_cnt <= '0;
      bar_pos  <= '0;
      bar_idx  <= 3'd0;
    end
  end

  // Line counter and per-frame pattern latch, both refreshed at VSYNC entry.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      line_cnt <= '0;
      patt     <= 2'd0;
    end else if (vsync_entry) begin
      line_cnt <= '0;
      patt     <= pattern_sel;
    end else if ((state == ST_HBLANK) && (tmr == HB_LAST) && (line_cnt != LINE_LAST)) begin
      line_cnt <= line_cnt + LW'(1);
    end
  end

`ifdef CAM_TPG_LFSR_EN
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  // LFSR reseeds each frame and steps once per emitted byte.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst)                    lfsr <= 16'hACE1;
    else if (vsync_entry)        lfsr <= 16'hACE1;
    else if (state == ST_ACTIVE) lfsr <= {lfsr_fb, lfsr[15:1]};
  end
`endif

  // Pattern byte for the current position, selected by the latched pattern.
  always_comb begin
    bar_rgb  = bar_colour(bar_idx);
    cnt_byte = 8'(byte_cnt) + 8'(line_cnt);
    pix      = 8'hAA;
    case (patt)
      2'd0: pix = 8'hAA;
      2'd1: pix = cnt_byte;
      2'd2: pix = byte_cnt[0] ? bar_rgb[7:0] : bar_rgb[15:8];
      2'd3: begin
`ifdef CAM_TPG_LFSR_EN
        pix = lfsr[7:0];
`else
        pix = cnt_byte;
`endif
      end
    endcase
  end

  // Registered outputs, one cycle behind the state they describe.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      vsync      <= 1'b0;
      href       <= 1'b0;
      data       <= 8'h00;
      frame_done <= 1'b0;
      frame_cnt  <= 16'd0;
      busy       <= 1'b0;
    end else begin
      vsync      <= (state == ST_VSYNC);
      href       <= (state == ST_ACTIVE);
      data       <= (state == ST_ACTIVE) ? pix : 8'h00;
      frame_done <= last_line_end;
      busy       <= (state != ST_IDLE);
      if (last_line_end) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_cam_timing_gen.sv
// tb_cam_timing_gen: directed bench for cam_timing_gen with a shortened frame
// (6 lines, short vertical blanking) so several frames fit in one run.
module tb_cam_timing_gen;

  localparam int H_ACTIVE = 640;
  localparam int H_BLANK  = 119;
  localparam int LINES    = 6;
  localparam int V_SYNC   = 20;
  localparam int V_BACK   = 30;
  localparam int V_FRONT  = 0;
  localparam int LIMIT    = 20000;

  logic        pclk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic        vsync;
  logic        href;
  logic [7:0]  data;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int timeouts     = 0;
  int done_seen    = 0;
  int cur_line     = -1;
  int pre_len, vs_len, bp_len, blank_bad;
  int h_len [LINES];
  int g_len [LINES];
  logic [7:0]  fb [LINES][H_ACTIVE];
  logic        done_at_end;
  logic [15:0] cnt_at_end;

  cam_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .LINES(LINES),
    .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_FRONT(V_FRONT)
  ) dut (
    .pclk(pclk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
    .vsync(vsync), .href(href), .data(data), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  // Free-running pixel clock.
  always #5 pclk = ~pclk;

  // Tally of frame_done pulses, used to prove each frame pulses exactly once.
  always @(negedge pclk) if (frame_done === 1'b1) done_seen++;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Walks one frame from before its vsync to the first blank cycle of the last line.
  task automatic capture_frame();
    int n;
    pre_len = 0;
    while (vsync !== 1'b1 && pre_len < LIMIT) begin pre_len++; @(negedge pclk); end
    if (pre_len >= LIMIT) timeouts++;
    vs_len = 0; blank_bad = 0;
    while (vsync === 1'b1 && vs_len < LIMIT) begin
      vs_len++; if (data !== 8'h00) blank_bad++; @(negedge pclk);
    end
    if (vs_len >= LIMIT) timeouts++;
    bp_len = 0;
    while (href !== 1'b1 && bp_len < LIMIT) begin
      bp_len++; if (data !== 8'h00) blank_bad++; @(negedge pclk);
    end
    if (bp_len >= LIMIT) timeouts++;
    for (int l = 0; l < LINES; l++) begin
      cur_line = l;
      n = 0;
      while (href === 1'b1 && n < LIMIT) begin
        if (n < H_ACTIVE) fb[l][n] = data;
        n++; @(negedge pclk);
      end
      if (n >= LIMIT) timeouts++;
      h_len[l] = n;
      if (l == LINES - 1) begin
        done_at_end = frame_done;
        cnt_at_end  = frame_cnt;
      end else begin
        n = 0;
        while (href !== 1'b1 && n < LIMIT) begin
          n++; if (data !== 8'h00) blank_bad++; @(negedge pclk);
        end
        if (n >= LIMIT) timeouts++;
        g_len[l] = n;
      end
    end
  endtask

  function automatic logic [7:0] model_bar(input int b);
    logic [15:0] tbl [8];
    logic [15:0] c;
    tbl = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    c = tbl[b / (H_ACTIVE / 8)];
    return (b % 2 == 1) ? c[7:0] : c[15:8];
  endfunction

  function automatic int count_bad_counter();
    int bad = 0;
    for (int l = 0; l < LINES; l++)
      for (int b = 0; b < H_ACTIVE; b++)
        if (fb[l][b] !== 8'(l + b)) bad++;
    return bad;
  endfunction

  initial begin
    int bad, vs_hits, rises, w;
    logic prev_href;
    logic [15:0] m;

    // Reset held with enable high: everything stays quiet.
    rst = 1'b0; enable = 1'b1; pattern_sel = 2'd0;
    repeat (5) @(negedge pclk);
    check_output("reset_vsync", vsync, 0);
    check_output("reset_href", href, 0);
    check_output("reset_data", data, 0);
    check_output("reset_frame_done", frame_done, 0);
    check_output("reset_frame_cnt", frame_cnt, 0);
    check_output("reset_busy", busy, 0);

    rst = 1'b1;
    @(negedge pclk);
    check_output("vsync_one_after_release", vsync, 0);
    @(negedge pclk);
    check_output("vsync_two_after_release", vsync, 1);
    check_output("busy_two_after_release", busy, 1);

    // Frame 1: constant pattern, full timing checks.
    capture_frame();
    check_output("f1_vsync_len", vs_len, V_SYNC);
    check_output("f1_back_porch", bp_len, V_BACK);
    check_output("f1_href_len_first", h_len[0], H_ACTIVE);
    check_output("f1_href_len_last", h_len[LINES-1], H_ACTIVE);
    check_output("f1_gap_first", g_len[0], H_BLANK);
    check_output("f1_gap_last", g_len[LINES-2], H_BLANK);
    check_output("f1_blank_data", blank_bad, 0);
    bad = 0;
    for (int l = 0; l < LINES; l++)
      for (int b = 0; b < H_ACTIVE; b++)
        if (fb[l][b] !== 8'hAA) bad++;
    check_output("f1_const_bytes", bad, 0);
    check_output("f1_frame_done", done_at_end, 1);
    check_output("f1_frame_cnt", cnt_at_end, 1);

    // Frame 2: counter pattern.
    pattern_sel = 2'd1;
    capture_frame();
    check_output("f2_gap_to_vsync", pre_len, H_BLANK + V_FRONT);
    check_output("f2_l0_b0", fb[0][0], 8'h00);
    check_output("f2_l0_b1", fb[0][1], 8'h01);
    check_output("f2_l0_b255", fb[0][255], 8'hFF);
    check_output("f2_l0_b256", fb[0][256], 8'h00);
    check_output("f2_l3_b0", fb[3][0], 8'h03);
    check_output("f2_all_bytes", count_bad_counter(), 0);
    check_output("f2_blank_data", blank_bad, 0);
    check_output("f2_frame_cnt", cnt_at_end, 2);

    // Frame 3: colour bars.
    pattern_sel = 2'd2;
    capture_frame();
    check_output("f3_b0", fb[0][0], 8'hFF);
    check_output("f3_b1", fb[0][1], 8'hFF);
    check_output("f3_b80", fb[0][80], 8'hFF);
    check_output("f3_b81", fb[0][81], 8'hE0);
    check_output("f3_b160", fb[0][160], 8'h07);
    check_output("f3_b161", fb[0][161], 8'hFF);
    check_output("f3_b638", fb[0][638], 8'h00);
    check_output("f3_b639", fb[0][639], 8'h00);
    bad = 0;
    for (int l = 0; l < LINES; l++)
      for (int b = 0; b < H_ACTIVE; b++)
        if (fb[l][b] !== model_bar(b)) bad++;
    check_output("f3_all_bytes", bad, 0);

    // Frame 4: pattern 3 (LFSR when enabled, otherwise the counter).
    pattern_sel = 2'd3;
    capture_frame();
`ifdef CAM_TPG_LFSR_EN
    check_output("f4_lfsr_first", fb[0][0], 8'hE1);
    m = 16'hACE1; bad = 0;
    for (int l = 0; l < LINES; l++)
      for (int b = 0; b < H_ACTIVE; b++) begin
        if (fb[l][b] !== m[7:0]) bad++;
        m = {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
      end
    check_output("f4_lfsr_all", bad, 0);
`else
    m = 16'h0000;
    check_output("f4_pat3_first", fb[0][0], 8'h00);
    check_output("f4_pat3_as_counter", count_bad_counter() + int'(m), 0);
`endif

    // Frame 5: enable dropped during line 3; the frame must still complete.
    pattern_sel = 2'd1;
    cur_line = -1;
    fork
      capture_frame();
      begin
        w = 0;
        while (cur_line != 3 && w < 4 * LIMIT) begin w++; @(negedge pclk); end
        if (w >= 4 * LIMIT) timeouts++;
        enable = 1'b0;
      end
    join
    check_output("f5_last_line_len", h_len[LINES-1], H_ACTIVE);
    check_output("f5_frame_done", done_at_end, 1);
    check_output("f5_frame_cnt", cnt_at_end, 5);
    vs_hits = 0;
    repeat (400) begin
      @(negedge pclk);
      if (vsync === 1'b1) vs_hits++;
    end
    check_output("f5_no_more_vsync", vs_hits, 0);
    check_output("f5_busy_idle", busy, 0);
    check_output("done_pulse_count", done_seen, 5);

    // Frame 6: reset asserted in the middle of line 4.
    enable = 1'b1;
    w = 0;
    while (vsync !== 1'b1 && w < LIMIT) begin w++; @(negedge pclk); end
    if (w >= LIMIT) timeouts++;
    rises = 0; prev_href = 1'b0; w = 0;
    while (rises < 5 && w < 4 * LIMIT) begin
      @(negedge pclk);
      w++;
      if (href === 1'b1 && prev_href === 1'b0) rises++;
      prev_href = href;
    end
    if (w >= 4 * LIMIT) timeouts++;
    repeat (10) @(negedge pclk);
    check_output("f6_href_before_reset", href, 1);
    check_output("f6_data_before_reset", data, 8'h0E);
    rst = 1'b0;
    #1;
    check_output("midreset_vsync", vsync, 0);
    check_output("midreset_href", href, 0);
    check_output("midreset_data", data, 0);
    check_output("midreset_frame_done", frame_done, 0);
    check_output("midreset_frame_cnt", frame_cnt, 0);
    check_output("midreset_busy", busy, 0);
    repeat (3) @(negedge pclk);
    rst = 1'b1;
    @(negedge pclk);
    check_output("restart_vsync_one", vsync, 0);
    @(negedge pclk);
    check_output("restart_vsync_two", vsync, 1);

    // Frame 7: clean restart from line 0.
    capture_frame();
    check_output("f7_vsync_len", vs_len, V_SYNC);
    check_output("f7_l0_b0", fb[0][0], 8'h00);
    check_output("f7_l4_b0", fb[4][0], 8'h04);
    check_output("f7_all_bytes", count_bad_counter(), 0);
    check_output("f7_frame_cnt", cnt_at_end, 1);
    check_output("wait_timeouts", timeouts, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
